// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end and the decoder.
//   fetch_state_t : fetch FSM state encoding (FETCH, IMM, IRQ)
//   IMM_OPCODE    : opcode high nibble that marks a two-byte instruction
//   DEF_RESET_VEC : default memory address holding the reset target
//   DEF_IRQ_VEC   : default memory address holding the interrupt target
//   is_two_byte() : true when an opcode is followed by an immediate byte
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        IMM   = 2'd1,
        IRQ   = 2'd2
    } fetch_state_t;

    localparam logic [3:0] IMM_OPCODE    = 4'hC;
    localparam logic [7:0] DEF_RESET_VEC = 8'h00;
    localparam logic [7:0] DEF_IRQ_VEC   = 8'h01;

    function automatic logic is_two_byte(input logic [7:0] opcode);
        return opcode[7:4] == IMM_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle between the fetch unit and its surroundings (PC register,
// instruction memory, hazard/EX control and the IF/ID consumer).
//   master : the fetch unit side
//   slave  : the environment side (PC register, memory, decode, hazard unit)
// Signals:
//   pc, stall, flush, interrupt, mem_rdata  -> into the fetch unit
//   mem_addr, vec_out, int_take, pc_en, pc_load, pc_imm,
//   if_instr, if_imm, if_pc, if_valid       -> out of the fetch unit
interface fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] pc;
    logic              stall;
    logic              flush;
    logic              interrupt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] vec_out;
    logic              int_take;
    logic              pc_en;
    logic              pc_load;
    logic              pc_imm;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_imm;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;

    modport master (
        input  pc, stall, flush, interrupt, mem_rdata,
        output mem_addr, vec_out, int_take, pc_en, pc_load, pc_imm,
               if_instr, if_imm, if_pc, if_valid
    );

    modport slave (
        output pc, stall, flush, interrupt, mem_rdata,
        input  mem_addr, vec_out, int_take, pc_en, pc_load, pc_imm,
               if_instr, if_imm, if_pc, if_valid
    );
endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst (sync, active-low) : clock and reset; reset empties the register
//   load                        : capture d_* and mark the entry valid
//   clear                       : empty the register (wins over load)
//   d_instr, d_imm, d_pc        : next opcode, immediate byte, opcode address
//   q_instr, q_imm, q_pc        : registered opcode, immediate, address
//   q_valid                     : register holds a real instruction
// With neither load nor clear the contents are held (stall behaviour).
module ifid_reg #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_instr,
    input  logic [DATA_W-1:0] d_imm,
    input  logic [ADDR_W-1:0] d_pc,
    output logic [DATA_W-1:0] q_instr,
    output logic [DATA_W-1:0] q_imm,
    output logic [ADDR_W-1:0] q_pc,
    output logic              q_valid
);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            q_instr <= '0;
            q_imm   <= '0;
            q_pc    <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q_instr <= d_instr;
            q_imm   <= d_imm;
            q_pc    <= d_pc;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Addresses instruction memory at the PC,
// reads the opcode (and the immediate at PC+1 for two-byte opcodes), fills
// the IF/ID register and tells the PC register how to advance.
// Ports:
//   clk        : clock
//   rst        : synchronous, active-low reset
//   bus        : fetch_if.master (PC value, stall/flush/interrupt, memory
//                address/data, vector output, PC control, IF/ID contents)
// Configuration macro FETCH_IRQ_EN: when defined, interrupt requests are
// latched and serviced through the IRQ state; when undefined the interrupt
// input is ignored and int_take is held at 0.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter int              DATA_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [ADDR_W-1:0] IRQ_VEC   = DEF_IRQ_VEC
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);

    fetch_state_t      state, state_next;
    logic [DATA_W-1:0] hold_op;
    logic [ADDR_W-1:0] hold_pc;
    logic              hold_load;
    logic              ifid_load, ifid_clear;
    logic [DATA_W-1:0] d_instr, d_imm;
    logic [ADDR_W-1:0] d_pc;
    logic              irq_take;

    // The PC register loads vec_out directly on reset and on int_take.
    assign bus.vec_out = bus.mem_rdata;

`ifdef FETCH_IRQ_EN
    logic int_prev, int_pend;

    // Only a rising request is latched; a held level does not re-arm after
    // service until it drops and rises again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            int_prev <= 1'b0;
            int_pend <= 1'b0;
        end else begin
            int_prev <= bus.interrupt;
            int_pend <= (int_pend && !bus.int_take) || (bus.interrupt && !int_prev);
        end
    end

    // Taking an IRQ between an opcode and its immediate would lose the
    // opcode, so only the FETCH state may accept it.
    assign irq_take = (state == FETCH) && int_pend && !bus.stall;
`else
    logic unused_interrupt;
    assign unused_interrupt = bus.interrupt;
    assign irq_take         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_op <= bus.mem_rdata;
            hold_pc <= bus.pc;
        end
    end

    always_comb begin
        state_next   = state;
        bus.mem_addr = bus.pc;
        bus.pc_en    = 1'b0;
        bus.pc_load  = 1'b1;
        bus.pc_imm   = 1'b0;
        bus.int_take = 1'b0;
        hold_load    = 1'b0;
        ifid_load    = 1'b0;
        ifid_clear   = 1'b0;
        d_instr      = bus.mem_rdata;
        d_imm        = '0;
        d_pc         = bus.pc;

        if (state == IMM) begin
            bus.mem_addr = bus.pc + ADDR_W'(1);
        end
`ifdef FETCH_IRQ_EN
        if (state == IRQ) begin
            bus.mem_addr = IRQ_VEC;
        end
`endif

        if (!rst) begin
            bus.mem_addr = RESET_VEC;
            state_next   = FETCH;
        end else if (bus.flush) begin
            // Target load; any half-fetched two-byte instruction is dropped.
            bus.pc_en   = 1'b1;
            bus.pc_load = 1'b0;
            ifid_clear  = 1'b1;
            state_next  = FETCH;
`ifdef FETCH_IRQ_EN
        end else if (state == IRQ) begin
            // PC loads vec_out (M[IRQ_VEC]) through its interrupt input.
            bus.int_take = 1'b1;
            state_next   = FETCH;
`endif
        end else if (irq_take) begin
            ifid_clear = 1'b1;
            state_next = IRQ;
        end else if (bus.stall) begin
            state_next = state;
        end else if (state == IMM) begin
            d_instr    = hold_op;
            d_imm      = bus.mem_rdata;
            d_pc       = hold_pc;
            ifid_load  = 1'b1;
            bus.pc_en  = 1'b1;
            bus.pc_imm = 1'b1;
            state_next = FETCH;
        end else if (is_two_byte(bus.mem_rdata)) begin
            hold_load  = 1'b1;
            ifid_clear = 1'b1;
            state_next = IMM;
        end else begin
            ifid_load = 1'b1;
            bus.pc_en = 1'b1;
        end
    end

    ifid_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ifid (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .clear   (ifid_clear),
        .d_instr (d_instr),
        .d_imm   (d_imm),
        .d_pc    (d_pc),
        .q_instr (bus.if_instr),
        .q_imm   (bus.if_imm),
        .q_pc    (bus.if_pc),
        .q_valid (bus.if_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a long
// randomized run. The bench also plays the PC register and instruction
// memory. Each cycle the stimulus side predicts the DUT's outputs from an
// instruction-level model and queues them; a monitor pops and compares.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic       stall_r, flush_r, int_r;
    logic [7:0] target;
    logic [7:0] pc_reg;
    logic [7:0] mem [256];

    fetch_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    assign bus.pc        = pc_reg;
    assign bus.stall     = stall_r;
    assign bus.flush     = flush_r;
    assign bus.interrupt = int_r;
    assign bus.mem_rdata = mem[bus.mem_addr];

    fetch_unit #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .RESET_VEC (8'h00),
        .IRQ_VEC   (8'h01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register behaviour as seen by the fetch unit.
    always @(posedge clk) begin
        if (!rst)              pc_reg <= bus.vec_out;
        else if (bus.int_take) pc_reg <= bus.vec_out;
        else if (bus.pc_en)    pc_reg <= bus.pc_load ? (pc_reg + (bus.pc_imm ? 8'd2 : 8'd1)) : target;
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] vec;
        logic       pc_en;
        logic       pc_load;
        logic       pc_imm;
        logic       int_take;
        logic       valid;
        logic [7:0] instr;
        logic [7:0] imm;
        logic [7:0] ipc;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Instruction-level model: what IF/ID holds, whether an opcode is
    // waiting for its immediate, and the interrupt bookkeeping.
    logic       m_valid, m_waiting, m_in_irq, m_pend, m_prev_int;
    logic [7:0] m_instr, m_imm, m_pc, m_wait_op, m_wait_pc;

    task automatic model_cycle();
        exp_t       e;
        logic [7:0] a, byte_rd;
        logic       rise, pend_keep;
        e.valid = m_valid; e.instr = m_instr; e.imm = m_imm; e.ipc = m_pc;
        if (!rst)          a = 8'h00;
        else if (m_in_irq) a = 8'h01;
        else if (m_waiting) a = pc_reg + 8'd1;
        else               a = pc_reg;
        byte_rd    = mem[a];
        e.addr     = a;
        e.vec      = byte_rd;
        e.pc_en    = 1'b0;
        e.pc_load  = 1'b1;
        e.pc_imm   = 1'b0;
        e.int_take = 1'b0;
        if (!rst) begin
            m_valid = 0; m_waiting = 0; m_in_irq = 0; m_pend = 0; m_prev_int = 0;
        end else begin
`ifdef FETCH_IRQ_EN
            rise = int_r && !m_prev_int;
`else
            rise = 1'b0;
`endif
            pend_keep = m_pend;
            if (flush_r) begin
                e.pc_en = 1; e.pc_load = 0;
                m_valid = 0; m_waiting = 0; m_in_irq = 0;
            end else if (m_in_irq) begin
                e.int_take = 1;
                m_in_irq   = 0;
                pend_keep  = 0;
            end else if (m_pend && !m_waiting && !stall_r) begin
                m_valid  = 0;
                m_in_irq = 1;
            end else if (stall_r) begin
                // everything frozen
            end else if (m_waiting) begin
                m_instr = m_wait_op; m_imm = byte_rd; m_pc = m_wait_pc; m_valid = 1;
                e.pc_en = 1; e.pc_imm = 1;
                m_waiting = 0;
            end else if (byte_rd[7:4] == 4'hC) begin
                m_waiting = 1; m_wait_op = byte_rd; m_wait_pc = pc_reg; m_valid = 0;
            end else begin
                m_instr = byte_rd; m_imm = 8'h00; m_pc = pc_reg; m_valid = 1;
                e.pc_en = 1; e.pc_imm = 0;
            end
            m_pend     = pend_keep || rise;
            m_prev_int = int_r;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic i,
                        input logic [7:0] t);
        @(posedge clk);
        #1;
        rst = r; stall_r = s; flush_r = f; int_r = i; target = t;
        model_cycle();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want)
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        else
            n_pass++;
    endtask

    // Monitor: compares once per cycle, on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            check("vec_out",  32'(bus.vec_out),  32'(e.vec));
            check("pc_en",    32'(bus.pc_en),    32'(e.pc_en));
            check("int_take", 32'(bus.int_take), 32'(e.int_take));
            check("if_valid", 32'(bus.if_valid), 32'(e.valid));
            if (e.pc_en) check("pc_load", 32'(bus.pc_load), 32'(e.pc_load));
            if (e.pc_en && e.pc_load) check("pc_imm", 32'(bus.pc_imm), 32'(e.pc_imm));
            if (e.valid) begin
                check("if_instr", 32'(bus.if_instr), 32'(e.instr));
                check("if_imm",   32'(bus.if_imm),   32'(e.imm));
                check("if_pc",    32'(bus.if_pc),    32'(e.ipc));
            end
        end
    end

    initial begin
        rst = 0; stall_r = 0; flush_r = 0; int_r = 0; target = 8'h00; pc_reg = 8'h00;
        m_valid = 0; m_waiting = 0; m_in_irq = 0; m_pend = 0; m_prev_int = 0;
        m_instr = 0; m_imm = 0; m_pc = 0; m_wait_op = 0; m_wait_pc = 0;
        for (int a = 0; a < 256; a++) begin
            if ($urandom_range(0, 99) < 30) mem[a] = {4'hC, 4'($urandom_range(0, 15))};
            else                            mem[a] = 8'($urandom_range(0, 255));
        end
        mem[8'h00] = 8'h40; mem[8'h01] = 8'h60;
        mem[8'h40] = 8'h12; mem[8'h41] = 8'h01; mem[8'h42] = 8'h02;
        mem[8'h50] = 8'hC3; mem[8'h51] = 8'h7A; mem[8'h52] = 8'h03;
        mem[8'h60] = 8'h04; mem[8'h61] = 8'h05;
        mem[8'hFF] = 8'hC0;

        // Reset: vector read from M[0].
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        // One-byte stream from 40.
        repeat (3) step(1, 0, 0, 0, 8'h00);
        // Two-byte C3 7A at 50.
        step(1, 0, 1, 0, 8'h50);
        repeat (3) step(1, 0, 0, 0, 8'h00);
        // Wrap: opcode at FF, immediate at 00.
        mem[8'h00] = 8'h55;
        step(1, 0, 1, 0, 8'hFF);
        repeat (3) step(1, 0, 0, 0, 8'h00);
        mem[8'h00] = 8'h40;
        // Stall three cycles in IMM, then flush under stall.
        step(1, 0, 1, 0, 8'h50);
        step(1, 0, 0, 0, 8'h00);
        repeat (3) step(1, 1, 0, 0, 8'h00);
        step(1, 1, 1, 0, 8'h40);
        repeat (2) step(1, 0, 0, 0, 8'h00);
        // Interrupt pulse in IMM, then a pulse during stall.
        step(1, 0, 1, 0, 8'h50);
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 1, 8'h00);
        repeat (3) step(1, 0, 0, 0, 8'h00);
        step(1, 1, 0, 1, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        step(1, 1, 0, 0, 8'h00);
        repeat (3) step(1, 0, 0, 0, 8'h00);

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            logic r, s, f, i;
            r = ($urandom_range(0, 99) >= 2);
            s = ($urandom_range(0, 99) < 25);
            f = ($urandom_range(0, 99) < 8);
            i = ($urandom_range(0, 99) < 10) ? ~int_r : int_r;
            step(r, s, f, i, 8'($urandom_range(0, 255)));
        end

        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
